// File: rtl/l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : l2_mem_responder
// Description : Line-granular main-memory responder for the L2 refill and
//               writeback port, with a fixed access latency.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [LINE_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [LINE_W-1:0] resp_rdata_o,
    output logic              resp_we_o,
    output logic              busy_o,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
);

    localparam int         c_off      = $clog2(LINE_W / 8);
    localparam int         c_idx      = $clog2(DEPTH_LINES);
    localparam logic [7:0] c_cnt_init = 8'(LATENCY - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]        r_state;
    logic [7:0]        r_cnt;
    logic              r_we;
    logic [c_idx-1:0]  r_idx;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_mem [DEPTH_LINES];

    logic              w_accept;
    logic              w_direct;
    logic              w_wait_done;
    logic              w_op;
    logic              w_op_we;
    logic [c_idx-1:0]  w_op_idx;
    logic [LINE_W-1:0] w_op_wdata;
    logic              w_unused;

    // Only the line-index field addresses the array; everything else aliases.
    assign w_unused    = ^req_addr_i;

    assign w_accept    = req_valid_i & req_ready_o & (r_state == c_st_idle);
    assign w_direct    = w_accept & (LATENCY == 1);
    assign w_wait_done = (r_state == c_st_wait) & (r_cnt == 8'd1);
    assign w_op        = w_direct | w_wait_done;

    // With a single-cycle latency the array op uses the request as presented.
    assign w_op_we     = w_direct ? req_we_i                     : r_we;
    assign w_op_idx    = w_direct ? req_addr_i[c_off +: c_idx]   : r_idx;
    assign w_op_wdata  = w_direct ? req_wdata_i                  : r_wdata;

    // Storage has no reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (w_op && w_op_we && !rst_i) begin
            r_mem[w_op_idx] <= w_op_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_st_idle;
            r_cnt        <= 8'd0;
            r_we         <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_we_o    <= 1'b0;
            busy_o       <= 1'b0;
            rd_cnt_o     <= 32'd0;
            wr_cnt_o     <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_we        <= req_we_i;
                        r_idx       <= req_addr_i[c_off +: c_idx];
                        r_wdata     <= req_wdata_i;
                        r_cnt       <= c_cnt_init;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        r_state     <= (LATENCY > 1) ? c_st_wait : c_st_resp;
                    end
                end
                c_st_wait: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (w_wait_done) begin
                        r_state <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    // Entry cycle raises valid; it then holds until the handshake.
                    if (!resp_valid_o) begin
                        resp_valid_o <= 1'b1;
                    end else if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        busy_o       <= 1'b0;
                        r_state      <= c_st_idle;
                        if (resp_we_o) begin
                            if (wr_cnt_o != 32'hFFFF_FFFF) wr_cnt_o <= wr_cnt_o + 32'd1;
                        end else begin
                            if (rd_cnt_o != 32'hFFFF_FFFF) rd_cnt_o <= rd_cnt_o + 32'd1;
                        end
                    end
                end
                default: begin
                    r_state      <= c_st_idle;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase

            if (w_op) begin
                resp_we_o    <= w_op_we;
                resp_rdata_o <= w_op_we ? w_op_wdata : r_mem[w_op_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_mem_responder
// Description : Directed scoreboard bench; instance 0 uses LATENCY=8,
//               instance 1 uses LATENCY=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_mem_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid  [2];
    logic         req_ready  [2];
    logic         req_we     [2];
    logic [31:0]  req_addr   [2];
    logic [127:0] req_wdata  [2];
    logic         resp_valid [2];
    logic         resp_ready [2];
    logic [127:0] resp_rdata [2];
    logic         resp_we    [2];
    logic         busy       [2];
    logic [31:0]  rd_cnt     [2];
    logic [31:0]  wr_cnt     [2];

    int n_vec  = 0;
    int n_fail = 0;
    logic [128:0] sb [$];

    localparam logic [127:0] c_d1  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] c_d2  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] c_old = 128'h0A0A_0A0A_0B0B_0B0B_0C0C_0C0C_0D0D_0D0D;
    localparam logic [127:0] c_new = 128'hF0F0_F0F0_E1E1_E1E1_D2D2_D2D2_C3C3_C3C3;
    localparam logic [127:0] c_d3  = 128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788;
    localparam logic [127:0] c_d4  = 128'h8877_6655_4433_2211_0FED_CBA9_8765_4321;
    localparam logic [127:0] c_d5  = 128'hCAFE_F00D_BAAD_C0DE_FEED_FACE_0BAD_BEEF;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        l2_mem_responder #(
            .ADDR_W      (32),
            .LINE_W      (128),
            .DEPTH_LINES (1024),
            .LATENCY     ((g == 0) ? 8 : 1)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .req_valid_i  (req_valid[g]),
            .req_ready_o  (req_ready[g]),
            .req_we_i     (req_we[g]),
            .req_addr_i   (req_addr[g]),
            .req_wdata_i  (req_wdata[g]),
            .resp_valid_o (resp_valid[g]),
            .resp_ready_i (resp_ready[g]),
            .resp_rdata_o (resp_rdata[g]),
            .resp_we_o    (resp_we[g]),
            .busy_o       (busy[g]),
            .rd_cnt_o     (rd_cnt[g]),
            .wr_cnt_o     (wr_cnt[g])
        );
    end

    function automatic void check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [127:0] wdata, input logic [127:0] exp, input int hold);
        int k;
        logic [128:0] e;
        k = 0;
        while (!req_ready[d] && k < 50) begin @(negedge clk); k++; end
        check("req_ready_before", 128'(req_ready[d]), 128'd1);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
        sb.push_back({we, exp});
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0; req_we[d] = ~we;
        req_addr[d] = $urandom; req_wdata[d] = {$urandom, $urandom, $urandom, $urandom};
        k = 0;
        while (!resp_valid[d] && k < 50) begin @(negedge clk); k++; end
        check("latency", 128'(k), (d == 0) ? 128'd8 : 128'd1);
        e = sb.pop_front();
        check("resp_rdata", resp_rdata[d], e[127:0]);
        check("resp_we", 128'(resp_we[d]), 128'(e[128]));
        check("req_ready_busy", 128'(req_ready[d]), 128'd0);
        check("busy", 128'(busy[d]), 128'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", 128'(resp_valid[d]), 128'd1);
            check("bp_rdata", resp_rdata[d], e[127:0]);
            check("bp_req_ready", 128'(req_ready[d]), 128'd0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[d] = 1'b0;
        check("valid_after_hs", 128'(resp_valid[d]), 128'd0);
        check("req_ready_after_hs", 128'(req_ready[d]), 128'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : main
        int i, got, t, last, seen;
        logic acc;
        logic [128:0] e;
        logic         t5_we   [3];
        logic [31:0]  t5_addr [3];
        logic [127:0] t5_data [3];
        t5_we   = '{1'b1, 1'b0, 1'b1};
        t5_addr = '{32'h100, 32'h100, 32'h200};
        t5_data = '{c_d3, 128'h0, c_d4};

        for (int j = 0; j < 2; j++) begin
            req_valid[j] = 1'b0; req_we[j] = 1'b0; req_addr[j] = '0;
            req_wdata[j] = '0; resp_ready[j] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", 128'(req_ready[0]), 128'd1);
        check("rst_resp_valid", 128'(resp_valid[0]), 128'd0);
        check("rst_resp_rdata", resp_rdata[0], 128'd0);
        check("rst_resp_we", 128'(resp_we[0]), 128'd0);
        check("rst_busy", 128'(busy[0]), 128'd0);
        check("rst_rd_cnt", 128'(rd_cnt[0]), 128'd0);
        check("rst_wr_cnt", 128'(wr_cnt[0]), 128'd0);
        check("rst_req_ready_l1", 128'(req_ready[1]), 128'd1);

        // Write then read back
        txn(0, 1'b1, 32'h0000_0040, c_d1, c_d1, 0);
        txn(0, 1'b0, 32'h0000_0040, 128'h0, c_d1, 0);
        check("t1_wr_cnt", 128'(wr_cnt[0]), 128'd1);
        check("t1_rd_cnt", 128'(rd_cnt[0]), 128'd1);

        // Response backpressure
        txn(0, 1'b0, 32'h0000_0040, 128'h0, c_d1, 5);
        check("t2_rd_cnt", 128'(rd_cnt[0]), 128'd2);

        // Address aliasing across the index field
        txn(0, 1'b1, 32'h0000_4040, c_d2, c_d2, 0);
        txn(0, 1'b0, 32'h0000_0040, 128'h0, c_d2, 0);
        check("t3_rd_cnt", 128'(rd_cnt[0]), 128'd3);

        // Reset during WAIT abandons the write
        txn(0, 1'b1, 32'h0000_0080, c_old, c_old, 0);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h80; req_wdata[0] = c_new;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t4_req_ready", 128'(req_ready[0]), 128'd1);
        check("t4_busy", 128'(busy[0]), 128'd0);
        check("t4_wr_cnt", 128'(wr_cnt[0]), 128'd0);
        seen = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (resp_valid[0]) seen++;
        end
        check("t4_no_resp", 128'(seen), 128'd0);
        txn(0, 1'b0, 32'h0000_0080, 128'h0, c_old, 0);

        // Back-to-back requests with valid held and ready tied high
        pulse_reset();
        resp_ready[0] = 1'b1;
        i = 0; got = 0; t = 0; last = 0;
        req_valid[0] = 1'b1; req_we[0] = t5_we[0]; req_addr[0] = t5_addr[0]; req_wdata[0] = t5_data[0];
        while ((i < 3 || got < 3) && t < 200) begin
            if (resp_valid[0]) begin
                e = sb.pop_front();
                check("t5_rdata", resp_rdata[0], e[127:0]);
                check("t5_we", 128'(resp_we[0]), 128'(e[128]));
                got++;
            end
            acc = req_valid[0] && req_ready[0];
            if (acc) sb.push_back({t5_we[i], (i == 1) ? c_d3 : t5_data[i]});
            @(posedge clk);
            t++;
            @(negedge clk);
            if (acc) begin
                if (i > 0) check("t5_spacing", 128'(t - last), 128'd10);
                last = t;
                i++;
                if (i < 3) begin
                    req_we[0] = t5_we[i]; req_addr[0] = t5_addr[i]; req_wdata[0] = t5_data[i];
                end else begin
                    req_valid[0] = 1'b0;
                end
            end
        end
        resp_ready[0] = 1'b0;
        req_valid[0] = 1'b0;
        check("t5_got", 128'(got), 128'd3);
        check("t5_wr_cnt", 128'(wr_cnt[0]), 128'd2);
        check("t5_rd_cnt", 128'(rd_cnt[0]), 128'd1);

        // Single-cycle latency instance
        txn(1, 1'b1, 32'h0000_0040, c_d5, c_d5, 0);
        txn(1, 1'b0, 32'h0000_0040, 128'h0, c_d5, 0);
        check("t6_rd_cnt", 128'(rd_cnt[1]), 128'd1);
        check("t6_wr_cnt", 128'(wr_cnt[1]), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
